// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM memory responders.
package avalon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  localparam logic [31:0] BOOT_BASE_DEFAULT = 32'hBFC0_0000;
  // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of a left-shifting register).
  localparam logic [7:0]  LFSR_TAPS         = 8'hB8;
  localparam logic [3:0]  BE_FULL           = 4'hF;
  // Wide enough for 15 fixed plus 3 random wait states.
  localparam int unsigned STALL_W           = 5;

  // One step of the stall-randomising LFSR.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avalon_addr_decode.sv
// Maps a byte address onto the two RAM windows: low data window and boot window.
module avalon_addr_decode
  import avalon_pkg::*;
#(
  parameter int unsigned DEPTH     = 2048,
  parameter logic [31:0] BOOT_BASE = BOOT_BASE_DEFAULT
) (
  input  logic [31:0]              address,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(2 * DEPTH);

  logic [31:0] offset;
  logic        hit_low;
  logic        hit_boot;

  // Window compare on the full address; the upper index bit selects the window.
  always_comb begin
    offset   = address - BOOT_BASE;
    hit_low  = address < WIN_BYTES;
    hit_boot = (address >= BOOT_BASE) && (offset < WIN_BYTES);
    hit      = hit_low | hit_boot;
    idx      = '0;
    if (hit_low) begin
      idx = {1'b0, address[IDX_W:2]};
    end else if (hit_boot) begin
      idx = {1'b1, offset[IDX_W:2]};
    end
  end

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory slave with programmable wait states and two address windows.
module avalon_mem_responder
  import avalon_pkg::*;
#(
  parameter int unsigned DEPTH        = 2048,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned RANDOM_STALL = 0,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5,
  parameter logic [31:0] BOOT_BASE    = BOOT_BASE_DEFAULT,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  state_e             state, state_d;
  logic [STALL_W-1:0] cnt, cnt_d;
  logic [STALL_W-1:0] stall_c, stall_q;
  logic [7:0]         lfsr, lfsr_d;
  logic               err_d;
  logic [IDX_W-1:0]   idx_q, dec_idx, rd_idx;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               rd_ok_q, wr_ok_q, rd_ok;
  logic               dec_hit, req, both;
  logic               accept, load_rd, do_write;

  avalon_addr_decode #(
    .DEPTH    (DEPTH),
    .BOOT_BASE(BOOT_BASE)
  ) u_decode (
    .address(address),
    .hit    (dec_hit),
    .idx    (dec_idx)
  );

  assign req         = read | write;
  assign both        = read & write;
  assign waitrequest = req && (state != ACK);
  assign stall_c     = STALL_W'(WAIT_CYCLES)
                     + ((RANDOM_STALL != 0) ? STALL_W'(lfsr[1:0]) : STALL_W'(0));
  // A read completing straight from IDLE has not latched its index yet.
  assign rd_idx      = accept ? dec_idx : idx_q;
  assign rd_ok       = accept ? (dec_hit & read & ~write) : rd_ok_q;

  // Next-state logic; IDLE counts as the first wait cycle of a transfer.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    lfsr_d   = lfsr;
    err_d    = err;
    accept   = 1'b0;
    load_rd  = 1'b0;
    do_write = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          lfsr_d = lfsr_step(lfsr);
          if (!dec_hit || both) err_d = 1'b1;
          if (stall_c <= STALL_W'(1)) begin
            state_d = ACK;
            load_rd = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = STALL_W'(1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == stall_q - STALL_W'(1)) begin
          state_d = ACK;
          load_rd = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + STALL_W'(1);
        end
      end
      ACK: begin
        state_d  = IDLE;
        do_write = wr_ok_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers and the read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lfsr     <= LFSR_SEED;
      err      <= 1'b0;
      readdata <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      lfsr  <= lfsr_d;
      err   <= err_d;
      if (load_rd) readdata <= rd_ok ? mem[rd_idx] : 32'h0;
    end
  end

  // Request capture at acceptance; the master holds the bus stable afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= dec_idx;
      wdata_q <= writedata;
      be_q    <= byteenable;
      stall_q <= stall_c;
      rd_ok_q <= dec_hit & read & ~write;
      wr_ok_q <= dec_hit & write & ~read;
    end
  end

  // Byte-lane write commit on the ACK edge, suppressed by reset.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Scoreboard bench for avalon_mem_responder with three parameterisations.
module tb_avalon_mem_responder;
  import avalon_pkg::*;

  localparam int unsigned DEPTH = 64;

  typedef struct {
    int          k;
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  int          sel = 0;

  logic [2:0]  rd_v, wr_v, wq, errv;
  logic [31:0] rdata [3];

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   waits [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_v[k] = read && (sel == k);
      wr_v[k] = write && (sel == k);
    end
  end

  avalon_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .address(address), .read(rd_v[0]), .write(wr_v[0]),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wq[0]),
    .readdata(rdata[0]), .err(errv[0]));

  avalon_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .address(address), .read(rd_v[1]), .write(wr_v[1]),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wq[1]),
    .readdata(rdata[1]), .err(errv[1]));

  avalon_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1), .RANDOM_STALL(1),
                         .LFSR_SEED(8'hA5)) ur (
    .clk(clk), .reset(reset), .address(address), .read(rd_v[2]), .write(wr_v[2]),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wq[2]),
    .readdata(rdata[2]), .err(errv[2]));

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: counts stall cycles and scores each completing transfer.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (reset || !(rd_v[k] || wr_v[k])) begin
        waits[k] = 0;
      end else if (wq[k]) begin
        waits[k]++;
      end else begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_completion: instance %0d, no transfer pending", k);
        end else begin
          e = q.pop_front();
          check("instance", 32'(k), 32'(e.k));
          check("wait_cycles", 32'(waits[k]), 32'(e.waits));
          if (e.chk_rd) check("readdata", rdata[k], e.rd);
          check("err", {31'b0, errv[k]}, {31'b0, e.err});
        end
        waits[k] = 0;
      end
    end
  end

  task automatic start(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    @(posedge clk);
    #1;
    sel = k; read = r; write = w; address = a; writedata = wd; byteenable = be;
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wq[k] && n < 100);
    if (wq[k]) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: instance %0d still stalled after %0d cycles", k, n);
    end
  endtask

  task automatic xfer(input int k, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input logic chk,
                      input logic [31:0] erd, input logic eerr, input int ew);
    exp_t e;
    e.k = k; e.chk_rd = chk; e.rd = erd; e.err = eerr; e.waits = ew;
    q.push_back(e);
    start(k, r, w, a, wd, be);
    wait_done(k);
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] be, input logic eerr, input int ew);
    xfer(k, 1'b0, 1'b1, a, wd, be, 1'b0, 32'h0, eerr, ew);
  endtask

  task automatic rd(input int k, input logic [31:0] a, input logic [31:0] erd,
                    input logic eerr, input int ew);
    xfer(k, 1'b1, 1'b0, a, 32'h0, BE_FULL, 1'b1, erd, eerr, ew);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [7:0] model_lfsr(input logic [7:0] m);
    return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  endfunction

  initial begin
    logic [7:0] m;
    int         a;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_waitrequest", {31'b0, wq[k]}, 32'h0);
      check("reset_readdata", rdata[k], 32'h0);
      check("reset_err", {31'b0, errv[k]}, 32'h0);
    end

    // Windows, boundaries and byte lanes on the single-wait instance.
    wr(0, 32'hBFC0_0000, 32'h2402_0005, BE_FULL, 1'b0, 1);
    wr(0, 32'h0000_0000, 32'hAAAA_5555, BE_FULL, 1'b0, 1);
    rd(0, 32'hBFC0_0000, 32'h2402_0005, 1'b0, 1);
    rd(0, 32'h0000_0000, 32'hAAAA_5555, 1'b0, 1);
    wr(0, 32'hBFC0_007C, 32'h0BAD_F00D, BE_FULL, 1'b0, 1);
    wr(0, 32'h0000_007C, 32'h1357_9BDF, BE_FULL, 1'b0, 1);
    rd(0, 32'hBFC0_007C, 32'h0BAD_F00D, 1'b0, 1);
    rd(0, 32'h0000_007C, 32'h1357_9BDF, 1'b0, 1);
    wr(0, 32'h0000_0010, 32'h1122_3344, BE_FULL, 1'b0, 1);
    wr(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0101, 1'b0, 1);
    rd(0, 32'h0000_0010, 32'h11AD_33EF, 1'b0, 1);
    rd(0, 32'h0000_0013, 32'h11AD_33EF, 1'b0, 1);

    // Decode misses and illegal read+write; err stays set.
    rd(0, 32'h4000_0000, 32'h0, 1'b1, 1);
    rd(0, 32'h0000_0010, 32'h11AD_33EF, 1'b1, 1);
    rd(0, 32'hBFC0_0080, 32'h0, 1'b1, 1);
    wr(0, 32'h0000_0080, 32'hFFFF_FFFF, BE_FULL, 1'b1, 1);
    rd(0, 32'h0000_0000, 32'hAAAA_5555, 1'b1, 1);
    xfer(0, 1'b1, 1'b1, 32'h0000_0010, 32'h0, BE_FULL, 1'b1, 32'h0, 1'b1, 1);
    rd(0, 32'h0000_0010, 32'h11AD_33EF, 1'b1, 1);

    // Three wait states, back-to-back reads, illegal op sets err.
    wr(1, 32'h0000_0008, 32'hCAFE_F00D, BE_FULL, 1'b0, 3);
    wr(1, 32'h0000_0010, 32'h0123_4567, BE_FULL, 1'b0, 3);
    rd(1, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 3);
    rd(1, 32'h0000_0010, 32'h0123_4567, 1'b0, 3);
    xfer(1, 1'b1, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, BE_FULL, 1'b1, 32'h0, 1'b1, 3);
    rd(1, 32'h0000_0008, 32'hCAFE_F00D, 1'b1, 3);
    wr(1, 32'h0000_0020, 32'h55AA_55AA, BE_FULL, 1'b1, 3);

    // Request dropped during WAIT: no memory effect.
    start(1, 1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, BE_FULL);
    @(posedge clk);
    #1;
    write = 1'b0;
    repeat (3) @(posedge clk);
    rd(1, 32'h0000_0020, 32'h55AA_55AA, 1'b1, 3);

    // Reset during WAIT of a write: aborted, RAM kept, err cleared.
    start(1, 1'b0, 1'b1, 32'h0000_0020, 32'h0F0F_0F0F, BE_FULL);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    write = 1'b0;
    @(negedge clk);
    check("after_reset_waitrequest", {31'b0, wq[1]}, 32'h0);
    check("after_reset_readdata", rdata[1], 32'h0);
    check("after_reset_err_u3", {31'b0, errv[1]}, 32'h0);
    check("after_reset_err_u1", {31'b0, errv[0]}, 32'h0);
    rd(1, 32'h0000_0020, 32'h55AA_55AA, 1'b0, 3);
    rd(0, 32'h0000_0010, 32'h11AD_33EF, 1'b0, 1);

    // Random stalls from the LFSR; the sequence must repeat after reset.
    for (int run = 0; run < 2; run++) begin
      pulse_reset();
      m = 8'hA5;
      for (int i = 0; i < 16; i++) begin
        wr(2, 32'(i * 4), 32'h1000_0000 + 32'(i) * 32'h0101_0101, BE_FULL, 1'b0,
           1 + int'(m[1:0]));
        m = model_lfsr(m);
      end
      for (int i = 0; i < 50; i++) begin
        a = (i * 7) % 16;
        rd(2, 32'(a * 4), 32'h1000_0000 + 32'(a) * 32'h0101_0101, 1'b0, 1 + int'(m[1:0]));
        m = model_lfsr(m);
      end
    end

    @(posedge clk);
    #1;
    read = 1'b0;
    write = 1'b0;
    repeat (4) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL pending_transfers: got %0d outstanding, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
